// File: rtl/spu_issue_pkg.sv
// Shared types, op ID codes and per-op classification for the SPU issue controller.
// Codes run 0x01..0x5B in contiguous groups so pipe and latency are range lookups.
package spu_issue_pkg;

    localparam int REGW    = 7;
    localparam int SB_LATW = 3;

    typedef enum logic { EVEN = 1'b0, ODD = 1'b1 } pipe_e;

    typedef struct packed {
        logic [6:0]      op;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] ra;
        logic [REGW-1:0] rb;
        logic [REGW-1:0] rc;
        logic            use_ra;
        logic            use_rb;
        logic            use_rc;
        logic            wr_rt;
    } slot_t;

    typedef struct packed {
        logic            valid;
        logic [6:0]      op;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] ra;
        logic [REGW-1:0] rb;
        logic [REGW-1:0] rc;
    } issue_t;

    // Even pipe: 0x01..0x38, odd pipe: 0x39..0x5B.
    localparam logic [6:0] OP_A      = 7'h01;  // fixed point / logical 0x01..0x0F
    localparam logic [6:0] OP_AI     = 7'h02;
    localparam logic [6:0] OP_SHL    = 7'h10;  // word shift/rotate, compares 0x10..0x1F
    localparam logic [6:0] OP_CEQ    = 7'h18;
    localparam logic [6:0] OP_MPY    = 7'h20;  // multiply 0x20..0x27
    localparam logic [6:0] OP_FA     = 7'h28;  // float 0x28..0x37
    localparam logic [6:0] OP_NOP    = 7'h38;
    localparam logic [6:0] OP_LQD    = 7'h39;  // load/store 0x39..0x41
    localparam logic [6:0] OP_STQD   = 7'h3D;
    localparam logic [6:0] OP_BR     = 7'h42;  // branches 0x42..0x4B
    localparam logic [6:0] OP_SHLQBY = 7'h4C;  // quad shift/rotate, gather, fsmbi, cntb 0x4C..0x56
    localparam logic [6:0] OP_FSMBI  = 7'h55;
    localparam logic [6:0] OP_CNTB   = 7'h56;
    localparam logic [6:0] OP_LNOP   = 7'h57;
    localparam logic [6:0] OP_STOP   = 7'h59;
    localparam logic [6:0] OP_MAX    = 7'h5B;

    function automatic logic op_illegal(logic [6:0] op);
        return (op == 7'h00) || (op > OP_MAX);
    endfunction

    function automatic pipe_e op_pipe(logic [6:0] op);
        return (op <= OP_NOP) ? EVEN : ODD;
    endfunction

    function automatic logic [SB_LATW-1:0] op_latency(logic [6:0] op);
        if (op <= 7'h0F)      return 3'd2;
        else if (op <= 7'h1F) return 3'd4;
        else if (op <= 7'h27) return 3'd7;
        else if (op <= 7'h37) return 3'd6;
        else if (op == 7'h38) return 3'd2;
        else if (op <= 7'h41) return 3'd6;
        else if (op <= 7'h4B) return 3'd2;
        else if (op <= 7'h58) return 3'd4;
        else                  return 3'd2;
    endfunction

    function automatic logic op_is_nop(logic [6:0] op);
        return (op == OP_NOP) || (op == OP_LNOP);
    endfunction

    // Nops carry a decoded wr_rt but never update the scoreboard.
    function automatic logic slot_writes(slot_t s);
        return s.wr_rt && !op_is_nop(s.op);
    endfunction

    function automatic issue_t to_issue(slot_t s);
        return '{valid: 1'b1, op: s.op, rt: s.rt, ra: s.ra, rb: s.rb, rc: s.rc};
    endfunction

endpackage

// File: rtl/spu_issue_ctrl_scoreboard.sv
// Per-register countdown scoreboard: a nonzero count means the register result is still in flight.
module spu_scoreboard
    import spu_issue_pkg::*;
#(
    parameter int NREGS = 128,
    parameter int LATW  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  slot_t             head,
    input  slot_t             tail,
    output logic              head_ok,
    output logic              tail_ok,
    input  logic              ld0_en,
    input  logic [REGW-1:0]   ld0_rt,
    input  logic [LATW-1:0]   ld0_lat,
    input  logic              ld1_en,
    input  logic [REGW-1:0]   ld1_rt,
    input  logic [LATW-1:0]   ld1_lat
);

    logic [LATW-1:0]  sb [NREGS];
    logic [NREGS-1:0] busy;

    function automatic logic slot_ok(slot_t s, logic [NREGS-1:0] b);
        return !(s.use_ra && b[s.ra]) && !(s.use_rb && b[s.rb]) &&
               !(s.use_rc && b[s.rc]) && !(slot_writes(s) && b[s.rt]);
    endfunction

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREGS; i++) busy[i] = (sb[i] != '0);
    end

    assign head_ok = slot_ok(head, busy);
    assign tail_ok = slot_ok(tail, busy);

    // A load overrides that register's decrement in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset)                              sb[i] <= '0;
            else if (ld0_en && ld0_rt == REGW'(i))  sb[i] <= ld0_lat;
            else if (ld1_en && ld1_rt == REGW'(i))  sb[i] <= ld1_lat;
            else if (sb[i] != '0)                   sb[i] <= sb[i] - 1'b1;
        end
    end

endmodule

// File: rtl/spu_issue_ctrl.sv
// In-order dual-issue controller: holds one decoded pair, issues head then tail to even/odd pipes.
// Issue outputs are combinational from the held pair, so an accepted pair can issue the next cycle.
module spu_issue_ctrl
    import spu_issue_pkg::*;
#(
    parameter int NREGS = 128,
    parameter int LATW  = 3
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   pair_valid,
    output logic   pair_ready,
    input  slot_t  slot0,
    input  slot_t  slot1,
    input  logic   flush,
    output issue_t even_issue,
    output issue_t odd_issue,
    output logic   halted,
    output logic   illegal_op
);

    slot_t head, tail;
    logic  head_v, tail_v;
    logic  head_ok, tail_ok;
    logic  h_ill, h_go, t_go, h_stop_go, t_raw, t_waw;

    spu_scoreboard #(.NREGS(NREGS), .LATW(LATW)) u_sb (
        .clk     (clk),
        .reset   (reset),
        .head    (head),
        .tail    (tail),
        .head_ok (head_ok),
        .tail_ok (tail_ok),
        .ld0_en  (h_go && slot_writes(head)),
        .ld0_rt  (head.rt),
        .ld0_lat (LATW'(op_latency(head.op))),
        .ld1_en  (t_go && slot_writes(tail)),
        .ld1_rt  (tail.rt),
        .ld1_lat (LATW'(op_latency(tail.op)))
    );

    always_comb begin
        h_ill = head_v && op_illegal(head.op);
        h_go  = head_v && !h_ill && head_ok && !flush && !halted;
        t_raw = slot_writes(head) &&
                ((tail.use_ra && tail.ra == head.rt) ||
                 (tail.use_rb && tail.rb == head.rt) ||
                 (tail.use_rc && tail.rc == head.rt));
        t_waw = slot_writes(tail) && (tail.rt == head.rt);
        // Tail only pairs with a head that issues; a stop head discards its tail.
        t_go  = h_go && tail_v && !op_illegal(tail.op) && tail_ok &&
                (op_pipe(tail.op) != op_pipe(head.op)) &&
                !t_raw && !t_waw && (head.op != OP_STOP);
        h_stop_go  = h_go && (head.op == OP_STOP);
        pair_ready = !halted && !flush && !h_stop_go &&
                     (!head_v || (h_go && (!tail_v || t_go)));
        illegal_op = h_ill && !flush;
    end

    always_comb begin
        even_issue = '0;
        odd_issue  = '0;
        if (h_go) begin
            if (op_pipe(head.op) == EVEN) even_issue = to_issue(head);
            else                          odd_issue  = to_issue(head);
        end
        if (t_go) begin
            if (op_pipe(tail.op) == EVEN) even_issue = to_issue(tail);
            else                          odd_issue  = to_issue(tail);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
            head   <= '0;
            tail   <= '0;
            halted <= 1'b0;
        end else if (flush) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (h_stop_go) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
            halted <= 1'b1;
        end else if (pair_valid && pair_ready) begin
            head   <= slot0;
            tail   <= slot1;
            head_v <= 1'b1;
            tail_v <= 1'b1;
        end else if (h_go || h_ill) begin
            if (t_go) begin
                head_v <= 1'b0;
                tail_v <= 1'b0;
            end else begin
                head   <= tail;
                head_v <= tail_v;
                tail_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Bench for spu_issue_ctrl: vector table, hand sequences and random traffic against a queue-based model.
module tb_spu_issue_ctrl;
    import spu_issue_pkg::*;

    logic   clk = 1'b0;
    logic   reset, pair_valid, flush;
    slot_t  slot0, slot1;
    logic   pair_ready, halted, illegal_op;
    issue_t even_issue, odd_issue;

    int n_tests = 0;
    int n_fail  = 0;

    spu_issue_ctrl #(.NREGS(128), .LATW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .slot0      (slot0),
        .slot1      (slot1),
        .flush      (flush),
        .even_issue (even_issue),
        .odd_issue  (odd_issue),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    slot_t q[$];
    int    sbm[128];
    bit    m_halt;

    function automatic bit m_illegal(logic [6:0] op);
        return op == 0 || op > 7'h5B;
    endfunction
    function automatic int m_pipe(logic [6:0] op);   // 0 even, 1 odd
        return (op <= 7'h38) ? 0 : 1;
    endfunction
    function automatic int m_lat(logic [6:0] op);
        if (op <= 7'h0F) return 2;       // simple fixed
        if (op <= 7'h1F) return 4;       // shift / compare
        if (op <= 7'h27) return 7;       // multiply
        if (op <= 7'h37) return 6;       // float
        if (op == 7'h38) return 2;
        if (op <= 7'h41) return 6;       // load / store
        if (op <= 7'h4B) return 2;       // branch
        if (op <= 7'h58) return 4;       // quad / perm
        return 2;
    endfunction
    function automatic bit m_writes(slot_t s);
        return s.wr_rt && s.op != OP_NOP && s.op != OP_LNOP;
    endfunction
    function automatic bit m_reads(slot_t s, logic [6:0] r);
        return (s.use_ra && s.ra == r) || (s.use_rb && s.rb == r) || (s.use_rc && s.rc == r);
    endfunction
    function automatic bit m_ready(slot_t s);
        return (!s.use_ra || sbm[s.ra] == 0) && (!s.use_rb || sbm[s.rb] == 0) &&
               (!s.use_rc || sbm[s.rc] == 0) && (!m_writes(s) || sbm[s.rt] == 0);
    endfunction
    function automatic issue_t m_iss(slot_t s);
        issue_t r;
        r.valid = 1'b1; r.op = s.op; r.rt = s.rt; r.ra = s.ra; r.rb = s.rb; r.rc = s.rc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input logic pv, input slot_t a, input slot_t b,
                               input logic fl, input logic rst);
        slot_t h, t;
        bit hg, tg, drop, e_ready;
        issue_t e_ev, e_od, a_ev, a_od;
        if (rst) begin
            q.delete();
            foreach (sbm[i]) sbm[i] = 0;
            m_halt = 0;
            return;
        end
        hg = 0; tg = 0; drop = 0; e_ev = '0; e_od = '0; h = '0; t = '0;
        if (!fl && !m_halt && q.size() > 0) begin
            h = q[0];
            if (m_illegal(h.op)) drop = 1;
            else hg = m_ready(h);
            if (hg && q.size() > 1) begin
                t = q[1];
                tg = !m_illegal(t.op) && m_pipe(t.op) != m_pipe(h.op) && m_ready(t) &&
                     h.op != OP_STOP && !(m_writes(h) && m_reads(t, h.rt)) &&
                     !(m_writes(t) && t.rt == h.rt);
            end
        end
        if (hg) begin if (m_pipe(h.op) == 0) e_ev = m_iss(h); else e_od = m_iss(h); end
        if (tg) begin if (m_pipe(t.op) == 0) e_ev = m_iss(t); else e_od = m_iss(t); end
        e_ready = !fl && !m_halt && !(hg && h.op == OP_STOP) &&
                  (q.size() == 0 || (hg && (q.size() == 1 || tg)));
        a_ev = even_issue.valid ? even_issue : '0;
        a_od = odd_issue.valid  ? odd_issue  : '0;
        chk("m_pair_ready", 64'(pair_ready), 64'(e_ready));
        chk("m_even_issue", 64'(a_ev), 64'(e_ev));
        chk("m_odd_issue",  64'(a_od), 64'(e_od));
        chk("m_halted",     64'(halted), 64'(m_halt));
        chk("m_illegal_op", 64'(illegal_op), 64'(drop));
        foreach (sbm[i]) if (sbm[i] > 0) sbm[i]--;
        if (hg && m_writes(h)) sbm[h.rt] = m_lat(h.op);
        if (tg && m_writes(t)) sbm[t.rt] = m_lat(t.op);
        if (fl) q.delete();
        else if (hg && h.op == OP_STOP) begin q.delete(); m_halt = 1; end
        else begin
            if (hg || drop) void'(q.pop_front());
            if (tg) void'(q.pop_front());
            if (pv && e_ready) begin q.push_back(a); q.push_back(b); end
        end
    endtask

    task automatic step(input logic pv, input slot_t a, input slot_t b,
                        input logic fl, input logic rst);
        @(negedge clk);
        pair_valid = pv; slot0 = a; slot1 = b; flush = fl; reset = rst;
        #1;
        model_cycle(pv, a, b, fl, rst);
    endtask

    task automatic idle(); step(1'b0, '0, '0, 1'b0, 1'b0); endtask
    task automatic do_reset(); step(1'b0, '0, '0, 1'b0, 1'b1); endtask

    function automatic slot_t mk(logic [6:0] op, int rt, int ra, int rb, int rc,
                                 bit ua, bit ub, bit uc, bit wr);
        slot_t s;
        s.op = op; s.rt = 7'(rt); s.ra = 7'(ra); s.rb = 7'(rb); s.rc = 7'(rc);
        s.use_ra = ua; s.use_rb = ub; s.use_rc = uc; s.wr_rt = wr;
        return s;
    endfunction

    function automatic slot_t rnd_slot();
        logic [6:0] ops [17];
        ops = '{OP_A, OP_AI, OP_SHL, OP_CEQ, OP_MPY, OP_FA, OP_NOP, OP_LQD, OP_STQD,
                OP_BR, OP_SHLQBY, OP_FSMBI, OP_CNTB, OP_LNOP, 7'h00, 7'h5C, 7'h7F};
        return mk(ops[$urandom_range(0, 16)], $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
    endfunction

    typedef struct {
        slot_t      s0, s1;
        logic       ev_v;
        logic [6:0] ev_op;
        logic       od_v;
        logic [6:0] od_op;
        logic       ill;
    } vec_t;

    vec_t  tbl[10];
    slot_t nop_o;

    initial begin
        int k_hit, low;
        nop_o = mk(OP_LNOP, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0] = '{mk(OP_A, 3, 1, 2, 0, 1, 1, 0, 1),       mk(OP_LQD, 4, 1, 0, 0, 1, 0, 0, 1),    1, OP_A,   1, OP_LQD,    0};
        tbl[1] = '{mk(OP_LQD, 10, 1, 0, 0, 1, 0, 0, 1),    mk(OP_A, 11, 12, 13, 0, 1, 1, 0, 1),   1, OP_A,   1, OP_LQD,    0};
        tbl[2] = '{mk(OP_A, 14, 1, 2, 0, 1, 1, 0, 1),      mk(OP_AI, 15, 14, 0, 0, 1, 0, 0, 1),   1, OP_A,   0, 7'h00,     0};
        tbl[3] = '{mk(OP_SHLQBY, 16, 1, 2, 0, 1, 1, 0, 1), mk(OP_CNTB, 17, 3, 0, 0, 1, 0, 0, 1),  0, 7'h00,  1, OP_SHLQBY, 0};
        tbl[4] = '{mk(7'h00, 18, 1, 2, 0, 1, 1, 0, 1),     mk(OP_A, 18, 1, 2, 0, 1, 1, 0, 1),     0, 7'h00,  0, 7'h00,     1};
        tbl[5] = '{mk(7'h5C, 19, 1, 2, 0, 1, 1, 0, 1),     nop_o,                                 0, 7'h00,  0, 7'h00,     1};
        tbl[6] = '{mk(OP_FA, 19, 1, 2, 0, 1, 1, 0, 1),     mk(OP_MPY, 20, 3, 4, 0, 1, 1, 0, 1),   1, OP_FA,  0, 7'h00,     0};
        tbl[7] = '{mk(OP_A, 21, 1, 2, 0, 1, 1, 0, 1),      mk(OP_LNOP, 21, 0, 0, 0, 0, 0, 0, 1),  1, OP_A,   1, OP_LNOP,   0};
        tbl[8] = '{mk(OP_A, 22, 1, 2, 0, 1, 1, 0, 1),      mk(OP_LQD, 22, 3, 0, 0, 1, 0, 0, 1),   1, OP_A,   0, 7'h00,     0};
        tbl[9] = '{mk(OP_A, 23, 1, 2, 0, 1, 1, 0, 1),      mk(OP_STQD, 0, 1, 0, 23, 1, 0, 1, 0),  1, OP_A,   0, 7'h00,     0};

        pair_valid = 0; slot0 = '0; slot1 = '0; flush = 0; reset = 1;
        do_reset(); do_reset();
        idle();
        chk("reset_ready",  64'(pair_ready), 64'd1);
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_even_v", 64'(even_issue.valid), 64'd0);

        // table vectors: outputs in the cycle after the pair is accepted
        foreach (tbl[r]) begin
            step(1'b1, tbl[r].s0, tbl[r].s1, 1'b0, 1'b0);
            chk("tbl_accept", 64'(pair_ready), 64'd1);
            idle();
            chk("tbl_even_v", 64'(even_issue.valid), 64'(tbl[r].ev_v));
            if (tbl[r].ev_v) chk("tbl_even_op", 64'(even_issue.op), 64'(tbl[r].ev_op));
            chk("tbl_odd_v", 64'(odd_issue.valid), 64'(tbl[r].od_v));
            if (tbl[r].od_v) chk("tbl_odd_op", 64'(odd_issue.op), 64'(tbl[r].od_op));
            chk("tbl_illegal", 64'(illegal_op), 64'(tbl[r].ill));
            repeat (10) idle();
        end

        // same-pipe RAW tail: a issues, ai waits for sb[5] to count down from 2
        do_reset();
        step(1'b1, mk(OP_A, 5, 1, 2, 0, 1, 1, 0, 1), mk(OP_AI, 6, 5, 0, 0, 1, 0, 0, 1), 1'b0, 1'b0);
        k_hit = -1;
        for (int k = 1; k <= 10; k++) begin
            idle();
            if (k == 1) chk("raw_head_op", 64'(even_issue.valid ? even_issue.op : 7'h0), 64'(OP_A));
            if (k_hit < 0 && even_issue.valid && even_issue.op == OP_AI) k_hit = k;
        end
        chk("raw_tail_cycle", 64'(k_hit), 64'd4);

        // multiply latency: dependent a held 7 cycles with pair_ready low
        do_reset();
        step(1'b1, mk(OP_MPY, 7, 1, 2, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        step(1'b1, mk(OP_A, 8, 7, 1, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        chk("mpy_issue", 64'(even_issue.valid ? even_issue.op : 7'h0), 64'(OP_MPY));
        chk("mpy_ready", 64'(pair_ready), 64'd1);
        low = 0; k_hit = -1;
        for (int k = 0; k < 15 && k_hit < 0; k++) begin
            idle();
            if (even_issue.valid) k_hit = k; else if (!pair_ready) low++;
        end
        chk("mpy_stall_cycles", 64'(low), 64'd7);
        chk("mpy_dep_issued", 64'(k_hit >= 0), 64'd1);

        // flush while head is stalled on RAW; scoreboard keeps counting
        do_reset();
        step(1'b1, mk(OP_MPY, 20, 1, 2, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        step(1'b1, mk(OP_A, 21, 20, 1, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        idle(); idle();
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_even_v", 64'(even_issue.valid), 64'd0);
        chk("flush_odd_v",  64'(odd_issue.valid), 64'd0);
        chk("flush_ready",  64'(pair_ready), 64'd0);
        step(1'b1, mk(OP_A, 22, 20, 1, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        chk("post_flush_empty", 64'(pair_ready), 64'd1);
        k_hit = -1;
        for (int j = 1; j <= 12; j++) begin
            idle();
            if (k_hit < 0 && even_issue.valid) k_hit = j;
        end
        chk("post_flush_issue", 64'(k_hit), 64'd4);

        // reset with sb[9]=5 pending
        do_reset();
        step(1'b1, mk(OP_MPY, 9, 1, 2, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        idle(); idle(); idle();
        do_reset();
        step(1'b1, mk(OP_A, 10, 9, 1, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
        chk("rst_ready",   64'(pair_ready), 64'd1);
        chk("rst_even_v",  64'(even_issue.valid), 64'd0);
        chk("rst_halted",  64'(halted), 64'd0);
        chk("rst_illegal", 64'(illegal_op), 64'd0);
        idle();
        chk("rst_reader_issue", 64'(even_issue.valid ? even_issue.op : 7'h0), 64'(OP_A));

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_slot(), rnd_slot(),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0));
        end

        // stop: issues odd, tail discarded, halted sticky, accepts ignored
        do_reset();
        step(1'b1, mk(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0), mk(OP_A, 3, 1, 2, 0, 1, 1, 0, 1), 1'b0, 1'b0);
        idle();
        chk("stop_odd", 64'(odd_issue.valid ? odd_issue.op : 7'h0), 64'(OP_STOP));
        chk("stop_even_v", 64'(even_issue.valid), 64'd0);
        chk("stop_halted_late", 64'(halted), 64'd0);
        chk("stop_ready", 64'(pair_ready), 64'd0);
        idle();
        chk("stop_halted", 64'(halted), 64'd1);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, mk(OP_A, 3, 1, 2, 0, 1, 1, 0, 1), nop_o, 1'b0, 1'b0);
            chk("halt_no_accept", 64'(pair_ready), 64'd0);
            chk("halt_no_issue", 64'({even_issue.valid, odd_issue.valid}), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
